adder_tree_pipe_acc: RTL and testbench

- Parametrised, fully pipelined binary adder tree: sums 2**LOG2_INPUTS operands of WIDTH bits per beat.
- Valid-tagged pipeline; every tree level is registered.
- Optional signed arithmetic.
- Optional frame accumulator: sums acc_len consecutive tree results before emitting one output.
- Successor to the fixed 8-input, unpipelined-level adder trees; used for dot-product and decimation reductions in the datapath.

---
 rtl/adder_tree_pipe_acc_if.sv | 27 ++
 rtl/adder_tree_pipe_acc.sv | 127 ++++++++++++
 tb/tb_adder_tree_pipe_acc.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_tree_pipe_acc_if.sv
// rtl/adder_tree_pipe_acc_if.sv - beat/result bus of the pipelined adder tree
interface adder_tree_pipe_acc_if #(
  parameter int WIDTH       = 22,
  parameter int LOG2_INPUTS = 3,
  parameter int ACC_CNT_W   = 8
);
  localparam int N  = 1 << LOG2_INPUTS;
  localparam int OW = WIDTH + LOG2_INPUTS + ACC_CNT_W;

  logic                   in_valid;
  logic [N*WIDTH-1:0]     in_data;
  logic                   acc_en;
  logic [ACC_CNT_W-1:0]   acc_len;
  logic                   out_valid;
  logic [OW-1:0]          out_sum;
  logic                   out_last;

  modport master (
    output in_valid, in_data, acc_en, acc_len,
    input  out_valid, out_sum, out_last
  );

  modport slave (
    input  in_valid, in_data, acc_en, acc_len,
    output out_valid, out_sum, out_last
  );
endinterface

// File: rtl/adder_tree_pipe_acc.sv
// rtl/adder_tree_pipe_acc.sv - registered-per-level adder tree with optional frame accumulator
module adder_tree_pipe_acc #(
  parameter int WIDTH       = 22,
  parameter int LOG2_INPUTS = 3,
  parameter bit SIGNED      = 1'b0,
  parameter int ACC_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_tree_pipe_acc_if.slave bus
);
  localparam int N  = 1 << LOG2_INPUTS;
  localparam int TW = WIDTH + LOG2_INPUTS;
  localparam int OW = TW + ACC_CNT_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  localparam logic [ACC_CNT_W-1:0] CNT_ONE = {{(ACC_CNT_W-1){1'b0}}, 1'b1};

  // Level l holds N>>l partial sums of WIDTH+l bits; level 0 is the input register.
  for (genvar l = 0; l <= LOG2_INPUTS; l++) begin : g_lvl
    localparam int W = WIDTH + l;
    localparam int M = N >> l;

    logic [W-1:0] sum_q [M];
    logic         vld_q;

    if (l == 0) begin : g_leaf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
          for (int k = 0; k < M; k++) sum_q[k] <= '0;
        end else begin
          vld_q <= bus.in_valid;
          for (int k = 0; k < M; k++) sum_q[k] <= bus.in_data[k*WIDTH +: WIDTH];
        end
      end
    end else begin : g_node
      localparam int PW = W - 1;

      // Extension bit is the operand MSB only in signed mode.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
          for (int k = 0; k < M; k++) sum_q[k] <= '0;
        end else begin
          vld_q <= g_lvl[l-1].vld_q;
          for (int k = 0; k < M; k++) begin
            sum_q[k] <= {SIGNED & g_lvl[l-1].sum_q[2*k][PW-1],   g_lvl[l-1].sum_q[2*k]}
                      + {SIGNED & g_lvl[l-1].sum_q[2*k+1][PW-1], g_lvl[l-1].sum_q[2*k+1]};
          end
        end
      end
    end
  end

  logic                 t_vld;
  logic [TW-1:0]        t_sum;
  logic [OW-1:0]        t_ext;
  logic [ACC_CNT_W-1:0] len_eff;
  logic [OW-1:0]        acc_next;
  logic                 frame_done;

  logic [0:0]           state_q;
  logic [OW-1:0]        acc_q;
  logic [ACC_CNT_W-1:0] cnt_q;
  logic [ACC_CNT_W-1:0] len_q;
  logic [OW-1:0]        out_sum_q;
  logic                 out_valid_q;
  logic                 out_last_q;

  assign t_vld      = g_lvl[LOG2_INPUTS].vld_q;
  assign t_sum      = g_lvl[LOG2_INPUTS].sum_q[0];
  assign t_ext      = {{ACC_CNT_W{SIGNED & t_sum[TW-1]}}, t_sum};
  assign len_eff    = (bus.acc_len == '0) ? CNT_ONE : bus.acc_len;
  assign acc_next   = acc_q + t_ext;
  assign frame_done = (cnt_q + CNT_ONE) == len_q;

  // acc_en/acc_len are only looked at when a frame starts in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      if (t_vld) begin
        case (state_q)
          ST_IDLE: begin
            if (!bus.acc_en || len_eff == CNT_ONE) begin
              out_sum_q   <= t_ext;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b1;
            end
            if (bus.acc_en) begin
              acc_q <= t_ext;
              cnt_q <= CNT_ONE;
              len_q <= len_eff;
              if (len_eff != CNT_ONE) state_q <= ST_ACCUM;
            end
          end
          ST_ACCUM: begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + CNT_ONE;
            if (frame_done) begin
              out_sum_q   <= acc_next;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.out_sum   = out_sum_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_adder_tree_pipe_acc.sv
// tb/tb_adder_tree_pipe_acc.sv - directed and scoreboard bench for adder_tree_pipe_acc
module tb_adder_tree_pipe_acc;
  localparam int WIDTH       = 22;
  localparam int LOG2_INPUTS = 3;
  localparam int ACC_CNT_W   = 8;
  localparam int N           = 8;
  localparam int DW          = N * WIDTH;
  localparam int OW          = 33;
  localparam int LAT         = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic [DW-1:0]        in_data = '0;
  logic                 acc_en = 1'b0;
  logic [ACC_CNT_W-1:0] acc_len = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bad_last = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_tree_pipe_acc_if #(.WIDTH(WIDTH), .LOG2_INPUTS(LOG2_INPUTS), .ACC_CNT_W(ACC_CNT_W)) bus_u ();
  adder_tree_pipe_acc_if #(.WIDTH(WIDTH), .LOG2_INPUTS(LOG2_INPUTS), .ACC_CNT_W(ACC_CNT_W)) bus_s ();

  assign bus_u.in_valid = in_valid;
  assign bus_u.in_data  = in_data;
  assign bus_u.acc_en   = acc_en;
  assign bus_u.acc_len  = acc_len;
  assign bus_s.in_valid = in_valid;
  assign bus_s.in_data  = in_data;
  assign bus_s.acc_en   = acc_en;
  assign bus_s.acc_len  = acc_len;

  adder_tree_pipe_acc #(.WIDTH(WIDTH), .LOG2_INPUTS(LOG2_INPUTS), .SIGNED(1'b0), .ACC_CNT_W(ACC_CNT_W))
    dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u));
  adder_tree_pipe_acc #(.WIDTH(WIDTH), .LOG2_INPUTS(LOG2_INPUTS), .SIGNED(1'b1), .ACC_CNT_W(ACC_CNT_W))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  logic [OW-1:0] qu_sum[$];
  logic [OW-1:0] qs_sum[$];
  int            qu_cyc[$];
  int            qs_cyc[$];
  logic          qu_last[$];
  logic          qs_last[$];

  always @(negedge clk) begin
    if (bus_u.out_valid) begin
      qu_sum.push_back(bus_u.out_sum); qu_cyc.push_back(cyc); qu_last.push_back(bus_u.out_last);
    end else if (bus_u.out_last) bad_last++;
    if (bus_s.out_valid) begin
      qs_sum.push_back(bus_s.out_sum); qs_cyc.push_back(cyc); qs_last.push_back(bus_s.out_last);
    end else if (bus_s.out_last) bad_last++;
  end

  task automatic clear_q;
    qu_sum.delete(); qu_cyc.delete(); qu_last.delete();
    qs_sum.delete(); qs_cyc.delete(); qs_last.delete();
  endtask

  task automatic fill(input logic [WIDTH-1:0] v, output logic [DW-1:0] d);
    for (int k = 0; k < N; k++) d[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic beat(input logic [DW-1:0] d, output int bc);
    in_valid = 1'b1;
    in_data  = d;
    bc       = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if (bus_u.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_u: got %b want 0", bus_u.out_valid); end
    checks++; if (bus_u.out_sum !== '0) begin errors++; $display("FAIL rst_sum_u: got %0d want 0", bus_u.out_sum); end
    checks++; if (bus_u.out_last !== 1'b0) begin errors++; $display("FAIL rst_last_u: got %b want 0", bus_u.out_last); end
    checks++; if (bus_s.out_valid !== 1'b0 || bus_s.out_sum !== '0 || bus_s.out_last !== 1'b0) begin
      errors++; $display("FAIL rst_s: got v=%b s=%0d l=%b want 0 0 0", bus_s.out_valid, bus_s.out_sum, bus_s.out_last);
    end
  endtask

  task automatic test_pass_through;
    logic [DW-1:0] d; int bc;
    clear_q(); acc_en = 1'b0; acc_len = 8'd3;
    fill(22'h3FFFFF, d); beat(d, bc); idle(8);
    checks++; if (qu_sum.size() !== 1 || qs_sum.size() !== 1) begin
      errors++; $display("FAIL pass_count: got %0d/%0d want 1/1", qu_sum.size(), qs_sum.size());
    end else begin
      checks++; if (qu_sum[0] !== 33'd33554424) begin errors++; $display("FAIL pass_sum_u: got %0d want 33554424", qu_sum[0]); end
      checks++; if (qu_cyc[0] !== bc + LAT) begin errors++; $display("FAIL pass_latency: got %0d want %0d", qu_cyc[0], bc + LAT); end
      checks++; if (qu_last[0] !== 1'b1) begin errors++; $display("FAIL pass_last: got %b want 1", qu_last[0]); end
      checks++; if (qs_sum[0] !== 33'h1FFFFFFF8) begin errors++; $display("FAIL pass_sum_s: got %h want 1fffffff8", qs_sum[0]); end
    end
  endtask

  task automatic test_signed_alt;
    logic [DW-1:0] d; int bc;
    clear_q(); acc_en = 1'b0;
    for (int k = 0; k < N; k++) d[k*WIDTH +: WIDTH] = (k % 2 == 0) ? 22'd5 : 22'h3FFFFD;
    beat(d, bc); idle(8);
    checks++; if (qu_sum.size() !== 1 || qs_sum.size() !== 1) begin
      errors++; $display("FAIL alt_count: got %0d/%0d want 1/1", qu_sum.size(), qs_sum.size());
    end else begin
      checks++; if (qs_sum[0] !== 33'd8) begin errors++; $display("FAIL alt_sum_s: got %0d want 8", qs_sum[0]); end
      checks++; if (qu_sum[0] !== 33'd16777224) begin errors++; $display("FAIL alt_sum_u: got %0d want 16777224", qu_sum[0]); end
    end
  endtask

  task automatic test_accum_bubbles;
    logic [DW-1:0] d; int bc;
    clear_q(); acc_en = 1'b1; acc_len = 8'd4; fill(22'd1, d);
    for (int b = 0; b < 4; b++) begin
      beat(d, bc);
      if (b < 3) idle(2);
    end
    acc_en = 1'b0; acc_len = 8'd1;
    idle(8);
    checks++; if (qu_sum.size() !== 1) begin
      errors++; $display("FAIL acc_count: got %0d want 1", qu_sum.size());
    end else begin
      checks++; if (qu_sum[0] !== 33'd32) begin errors++; $display("FAIL acc_sum: got %0d want 32", qu_sum[0]); end
      checks++; if (qu_cyc[0] !== bc + LAT) begin errors++; $display("FAIL acc_latency: got %0d want %0d", qu_cyc[0], bc + LAT); end
      checks++; if (qu_last[0] !== 1'b1) begin errors++; $display("FAIL acc_last: got %b want 1", qu_last[0]); end
    end
    checks++; if (qs_sum.size() !== 1 || qs_sum[0] !== 33'd32) begin
      errors++; $display("FAIL acc_sum_s: got n=%0d want one output of 32", qs_sum.size());
    end
  endtask

  task automatic test_len_zero;
    logic [DW-1:0] d; int bc[3];
    clear_q(); acc_en = 1'b1; acc_len = 8'd0;
    for (int b = 0; b < 3; b++) begin
      fill(WIDTH'(b + 1), d); beat(d, bc[b]);
    end
    idle(8);
    checks++; if (qu_sum.size() !== 3) begin
      errors++; $display("FAIL len0_count: got %0d want 3", qu_sum.size());
    end else begin
      for (int b = 0; b < 3; b++) begin
        checks++; if (qu_sum[b] !== OW'(8 * (b + 1)) || qu_cyc[b] !== bc[b] + LAT || qu_last[b] !== 1'b1) begin
          errors++; $display("FAIL len0_out%0d: got %0d@%0d want %0d@%0d", b, qu_sum[b], qu_cyc[b], 8 * (b + 1), bc[b] + LAT);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] d; int bc[6];
    clear_q(); acc_en = 1'b1; acc_len = 8'd2; fill(22'd1, d);
    for (int b = 0; b < 6; b++) beat(d, bc[b]);
    idle(8);
    checks++; if (qu_sum.size() !== 3) begin
      errors++; $display("FAIL b2b_count: got %0d want 3", qu_sum.size());
    end else begin
      for (int f = 0; f < 3; f++) begin
        checks++; if (qu_sum[f] !== 33'd16 || qu_cyc[f] !== bc[2*f+1] + LAT || qu_last[f] !== 1'b1) begin
          errors++; $display("FAIL b2b_out%0d: got %0d@%0d want 16@%0d", f, qu_sum[f], qu_cyc[f], bc[2*f+1] + LAT);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [DW-1:0] d; int bc;
    clear_q(); acc_en = 1'b1; acc_len = 8'd4; fill(22'd1, d);
    beat(d, bc); beat(d, bc); idle(6);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus_u.out_sum !== '0 || bus_u.out_valid !== 1'b0 || bus_u.out_last !== 1'b0) begin
      errors++; $display("FAIL midrst_clear: got v=%b s=%0d l=%b want 0 0 0", bus_u.out_valid, bus_u.out_sum, bus_u.out_last);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    idle(8);
    checks++; if (qu_sum.size() !== 0) begin errors++; $display("FAIL midrst_quiet: got %0d outputs want 0", qu_sum.size()); end
    clear_q();
    for (int b = 0; b < 4; b++) beat(d, bc);
    idle(8);
    checks++; if (qu_sum.size() !== 1 || qu_sum[0] !== 33'd32 || qu_cyc[0] !== bc + LAT) begin
      errors++; $display("FAIL midrst_next: got n=%0d want one output 32@%0d", qu_sum.size(), bc + LAT);
    end
  endtask

  task automatic test_random(input logic mode_acc, input logic [ACC_CNT_W-1:0] len, input int nbeats);
    logic [OW-1:0] exp_u[$], exp_s[$];
    int            exp_c[$];
    logic [OW-1:0] sum_u, sum_s;
    logic [DW-1:0] d;
    logic [WIDTH-1:0] op;
    int cnt, bc, n;
    clear_q(); acc_en = mode_acc; acc_len = len;
    sum_u = '0; sum_s = '0; cnt = 0;
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < N; k++) begin
        op = WIDTH'($urandom);
        d[k*WIDTH +: WIDTH] = op;
        sum_u = sum_u + {{(OW-WIDTH){1'b0}}, op};
        sum_s = sum_s + {{(OW-WIDTH){op[WIDTH-1]}}, op};
      end
      beat(d, bc);
      cnt++;
      if (!mode_acc || cnt == int'(len)) begin
        exp_u.push_back(sum_u); exp_s.push_back(sum_s); exp_c.push_back(bc + LAT);
        sum_u = '0; sum_s = '0; cnt = 0;
      end
    end
    idle(10);
    checks++; if (qu_sum.size() !== exp_u.size() || qs_sum.size() !== exp_s.size()) begin
      errors++; $display("FAIL rnd%0d_count: got %0d/%0d want %0d", mode_acc, qu_sum.size(), qs_sum.size(), exp_u.size());
    end
    n = (qu_sum.size() < exp_u.size()) ? qu_sum.size() : exp_u.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (qu_sum[i] !== exp_u[i] || qu_cyc[i] !== exp_c[i] || qu_last[i] !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_u[%0d]: got %h@%0d want %h@%0d", mode_acc, i, qu_sum[i], qu_cyc[i], exp_u[i], exp_c[i]);
      end
    end
    n = (qs_sum.size() < exp_s.size()) ? qs_sum.size() : exp_s.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (qs_sum[i] !== exp_s[i] || qs_cyc[i] !== exp_c[i] || qs_last[i] !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_s[%0d]: got %h@%0d want %h@%0d", mode_acc, i, qs_sum[i], qs_cyc[i], exp_s[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_last_idle;
    checks++; if (bad_last !== 0) begin errors++; $display("FAIL last_idle: got %0d stray out_last want 0", bad_last); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    idle(2);
    test_pass_through();
    test_signed_alt();
    test_accum_bubbles();
    test_len_zero();
    test_back_to_back();
    test_reset_mid_frame();
    test_random(1'b0, 8'd1, 1000);
    test_random(1'b1, 8'd3, 999);
    test_last_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
